vend_ctrl_multi: RTL and testbench

//  Parametrised vending controller: N products with per-product price table and stock counters,

---
 rtl/vend_pkg.sv | 33 +++
 rtl/vend_change_pick.sv | 35 +++
 rtl/vend_ctrl_multi.sv | 161 ++++++++++++++++
 tb/tb_vend_ctrl_multi.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// +----------------------------------------------------------------------------+
// | Package     : vend_pkg                                                     |
// | Description : Shared state encoding, error codes and coin denominations    |
// |               for the multi-product vending controller.                    |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
`default_nettype none

package vend_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_CREDIT = 3'd1,
      ST_VEND   = 3'd2,
      ST_CHANGE = 3'd3
   } vend_state_e;

   localparam logic [1:0] c_err_invalid_coin = 2'd0;
   localparam logic [1:0] c_err_overflow     = 2'd1;
   localparam logic [1:0] c_err_insufficient = 2'd2;
   localparam logic [1:0] c_err_sold_out     = 2'd3;

   localparam logic [3:0] c_coin_1  = 4'd1;
   localparam logic [3:0] c_coin_5  = 4'd5;
   localparam logic [3:0] c_coin_10 = 4'd10;

   function automatic logic coin_is_valid(input logic [3:0] value);
      return (value == c_coin_1) || (value == c_coin_5) || (value == c_coin_10);
   endfunction

endpackage

`default_nettype wire

// File: rtl/vend_change_pick.sv
// +----------------------------------------------------------------------------+
// | Module      : vend_change_pick                                             |
// | Description : Combinational greedy change picker (10/5/1).                 |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
`default_nettype none

module vend_change_pick
   import vend_pkg::*;
#(
   parameter int CREDIT_W = 8
) (
   input  logic [CREDIT_W-1:0] remaining,
   output logic [3:0]          coin_val,
   output logic [CREDIT_W-1:0] remaining_next
);

   localparam logic [CREDIT_W-1:0] c_ten  = CREDIT_W'(c_coin_10);
   localparam logic [CREDIT_W-1:0] c_five = CREDIT_W'(c_coin_5);

   always_comb begin
      coin_val = 4'd0;
      if (remaining >= c_ten) begin
         coin_val = c_coin_10;
      end else if (remaining >= c_five) begin
         coin_val = c_coin_5;
      end else if (remaining != '0) begin
         coin_val = c_coin_1;
      end
      remaining_next = remaining - CREDIT_W'(coin_val);
   end

endmodule

`default_nettype wire

// File: rtl/vend_ctrl_multi.sv
// +----------------------------------------------------------------------------+
// | Module      : vend_ctrl_multi                                              |
// | Description : N-product vending controller with price table, stock,        |
// |               credit, cancel/refund and coin-by-coin change payout.        |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
`default_nettype none

module vend_ctrl_multi
   import vend_pkg::*;
#(
   parameter int                           NUM_PROD    = 4,
   parameter int                           CREDIT_W    = 8,
   parameter int                           STOCK_W     = 4,
   parameter int                           INIT_STOCK  = 5,
   parameter int                           MAX_CREDIT  = 200,
   parameter logic [NUM_PROD*CREDIT_W-1:0] PRICE_TABLE = {8'd20, 8'd15, 8'd10, 8'd5},
   localparam int                          SEL_W       = $clog2(NUM_PROD)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [3:0]          coin,
   input  logic                coin_insert,
   input  logic [SEL_W-1:0]    product_sel,
   input  logic                dispense_req,
   input  logic                cancel,
   input  logic                restock,
   output logic [CREDIT_W-1:0] credit,
   output logic                dispense,
   output logic [SEL_W-1:0]    dispensed_id,
   output logic [3:0]          coin_out,
   output logic                coin_out_vld,
   output logic                error,
   output logic [1:0]          err_code,
   output logic                busy,
   output logic [2:0]          state
);

   localparam logic [CREDIT_W:0]  c_max_credit = (CREDIT_W+1)'(MAX_CREDIT);
   localparam logic [STOCK_W-1:0] c_init_stock = STOCK_W'(INIT_STOCK);
   localparam logic [SEL_W:0]     c_num_prod   = (SEL_W+1)'(NUM_PROD);

   vend_state_e         state_q, state_d;
   logic [CREDIT_W-1:0] credit_q, credit_d;
   logic [SEL_W-1:0]    sel_id_q, sel_id_d;
   logic                error_q, error_d;
   logic [1:0]          err_code_q, err_code_d;
   logic [STOCK_W-1:0]  stock_q [NUM_PROD];
   logic [STOCK_W-1:0]  stock_d [NUM_PROD];

   logic [CREDIT_W-1:0] price_tab [NUM_PROD];
   logic [CREDIT_W-1:0] price_sel;
   logic [CREDIT_W-1:0] price_vend;
   logic [CREDIT_W:0]   coin_sum;
   logic                sel_ok;
   logic [3:0]          change_coin;
   logic [CREDIT_W-1:0] change_rem;

   for (genvar i = 0; i < NUM_PROD; i++) begin : g_price
      assign price_tab[i] = PRICE_TABLE[i*CREDIT_W +: CREDIT_W];
   end

   // Non-power-of-two product counts leave unused select codes; treat them as sold out.
   assign sel_ok     = {1'b0, product_sel} < c_num_prod;
   assign price_sel  = price_tab[product_sel];
   assign price_vend = price_tab[sel_id_q];
   assign coin_sum   = {1'b0, credit_q} + (CREDIT_W+1)'(coin);

   vend_change_pick #(
      .CREDIT_W (CREDIT_W)
   ) u_change_pick (
      .remaining      (credit_q),
      .coin_val       (change_coin),
      .remaining_next (change_rem)
   );

   always_comb begin
      state_d    = state_q;
      credit_d   = credit_q;
      sel_id_d   = sel_id_q;
      error_d    = 1'b0;
      err_code_d = err_code_q;
      stock_d    = stock_q;

      case (state_q)
         ST_IDLE, ST_CREDIT: begin
            if (cancel) begin
               if (state_q == ST_CREDIT) state_d = ST_CHANGE;
            end else if (coin_insert) begin
               if (!coin_is_valid(coin)) begin
                  error_d    = 1'b1;
                  err_code_d = c_err_invalid_coin;
               end else if (coin_sum > c_max_credit) begin
                  error_d    = 1'b1;
                  err_code_d = c_err_overflow;
               end else begin
                  credit_d = coin_sum[CREDIT_W-1:0];
                  state_d  = ST_CREDIT;
               end
            end else if (dispense_req) begin
               if (!sel_ok || (stock_q[product_sel] == '0)) begin
                  error_d    = 1'b1;
                  err_code_d = c_err_sold_out;
               end else if ({1'b0, credit_q} < {1'b0, price_sel}) begin
                  error_d    = 1'b1;
                  err_code_d = c_err_insufficient;
               end else begin
                  sel_id_d = product_sel;
                  state_d  = ST_VEND;
               end
            end else if (restock && (state_q == ST_IDLE) && sel_ok) begin
               stock_d[product_sel] = c_init_stock;
            end
         end

         ST_VEND: begin
            stock_d[sel_id_q] = stock_q[sel_id_q] - STOCK_W'(1);
            credit_d          = credit_q - price_vend;
            state_d           = (credit_d != '0) ? ST_CHANGE : ST_IDLE;
         end

         ST_CHANGE: begin
            credit_d = change_rem;
            if (change_rem == '0) state_d = ST_IDLE;
         end

         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         credit_q   <= '0;
         sel_id_q   <= '0;
         error_q    <= 1'b0;
         err_code_q <= c_err_invalid_coin;
         for (int i = 0; i < NUM_PROD; i++) stock_q[i] <= c_init_stock;
      end else begin
         state_q    <= state_d;
         credit_q   <= credit_d;
         sel_id_q   <= sel_id_d;
         error_q    <= error_d;
         err_code_q <= err_code_d;
         stock_q    <= stock_d;
      end
   end

   assign credit       = credit_q;
   assign dispense     = (state_q == ST_VEND);
   assign dispensed_id = sel_id_q;
   assign coin_out_vld = (state_q == ST_CHANGE);
   assign coin_out     = coin_out_vld ? change_coin : 4'd0;
   assign error        = error_q;
   assign err_code     = err_code_q;
   assign busy         = (state_q == ST_VEND) || (state_q == ST_CHANGE);
   assign state        = state_q;

endmodule

`default_nettype wire

// File: tb/tb_vend_ctrl_multi.sv
// +----------------------------------------------------------------------------+
// | Module      : tb_vend_ctrl_multi                                           |
// | Description : Scoreboard bench: reference model pushes expected dispense,  |
// |               change-coin and error events; a monitor pops and compares.   |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_vend_ctrl_multi;

   localparam int K_DISP = 0;
   localparam int K_COIN = 1;
   localparam int K_ERR  = 2;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] coin;
   logic       coin_insert;
   logic [1:0] product_sel;
   logic       dispense_req;
   logic       cancel;
   logic       restock;
   logic [7:0] credit;
   logic       dispense;
   logic [1:0] dispensed_id;
   logic [3:0] coin_out;
   logic       coin_out_vld;
   logic       error;
   logic [1:0] err_code;
   logic       busy;
   logic [2:0] state;

   always #5 clk = ~clk;

   vend_ctrl_multi u_dut (
      .clk          (clk),
      .rst          (rst),
      .coin         (coin),
      .coin_insert  (coin_insert),
      .product_sel  (product_sel),
      .dispense_req (dispense_req),
      .cancel       (cancel),
      .restock      (restock),
      .credit       (credit),
      .dispense     (dispense),
      .dispensed_id (dispensed_id),
      .coin_out     (coin_out),
      .coin_out_vld (coin_out_vld),
      .error        (error),
      .err_code     (err_code),
      .busy         (busy),
      .state        (state)
   );

   typedef struct {
      int kind;
      int val;
   } exp_t;

   exp_t exp_q[$];
   int   vectors     = 0;
   int   miscompares = 0;
   int   m_credit;
   int   m_stock [4];
   int   prices  [4] = '{5, 10, 15, 20};

   task automatic check(input string name, input int act, input int exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Change is paid largest-coin-first from the denominations 10, 5, 1.
   task automatic push_change(input int amount);
      int left;
      int c;
      left = amount;
      while (left > 0) begin
         c = (left >= 10) ? 10 : (left >= 5) ? 5 : 1;
         exp_q.push_back('{K_COIN, c});
         left -= c;
      end
   endtask

   task automatic model_reset();
      m_credit = 0;
      for (int i = 0; i < 4; i++) m_stock[i] = 5;
   endtask

   task automatic model_event(input bit ci, input int c, input bit rq, input int sel,
                              input bit cn, input bit rs);
      if (cn) begin
         if (m_credit > 0) push_change(m_credit);
         m_credit = 0;
      end else if (ci) begin
         if (!(c == 1 || c == 5 || c == 10)) exp_q.push_back('{K_ERR, 0});
         else if (m_credit + c > 200)       exp_q.push_back('{K_ERR, 1});
         else                               m_credit += c;
      end else if (rq) begin
         if (m_stock[sel] == 0)              exp_q.push_back('{K_ERR, 3});
         else if (m_credit < prices[sel])    exp_q.push_back('{K_ERR, 2});
         else begin
            exp_q.push_back('{K_DISP, sel});
            m_stock[sel]--;
            push_change(m_credit - prices[sel]);
            m_credit = 0;
         end
      end else if (rs && m_credit == 0) begin
         m_stock[sel] = 5;
      end
   endtask

   task automatic pop_check(input int kind, input int val, input string name);
      exp_t e;
      if (exp_q.size() == 0) begin
         vectors++;
         miscompares++;
         $display("FAIL unexpected %s: got %0d expected no event", name, val);
      end else begin
         e = exp_q.pop_front();
         check(name, kind * 100 + val, e.kind * 100 + e.val);
      end
   endtask

   initial begin
      forever begin
         @(negedge clk);
         if (!rst) begin
            if (dispense)     pop_check(K_DISP, int'(dispensed_id), "dispense_id");
            if (coin_out_vld) pop_check(K_COIN, int'(coin_out), "coin_out");
            if (error)        pop_check(K_ERR, int'(err_code), "err_code");
         end
      end
   end

   task automatic clear_inputs();
      coin         = 4'd0;
      coin_insert  = 1'b0;
      product_sel  = 2'd0;
      dispense_req = 1'b0;
      cancel       = 1'b0;
      restock      = 1'b0;
   endtask

   task automatic issue(input bit ci, input logic [3:0] c, input bit rq, input logic [1:0] sel,
                        input bit cn, input bit rs);
      @(negedge clk);
      coin_insert  = ci;
      coin         = c;
      dispense_req = rq;
      product_sel  = sel;
      cancel       = cn;
      restock      = rs;
      model_event(ci, int'(c), rq, int'(sel), cn, rs);
      @(negedge clk);
      clear_inputs();
      for (int k = 0; k < 64; k++) begin
         if (!busy) break;
         // Requests while busy must be ignored entirely.
         coin_insert  = 1'($urandom_range(0, 1));
         coin         = 4'($urandom_range(0, 15));
         dispense_req = 1'($urandom_range(0, 1));
         product_sel  = 2'($urandom_range(0, 3));
         cancel       = 1'($urandom_range(0, 1));
         restock      = 1'($urandom_range(0, 1));
         @(negedge clk);
         clear_inputs();
      end
      check("busy_timeout", int'(busy), 0);
      check("credit", int'(credit), m_credit);
      check("state", int'(state), (m_credit > 0) ? 1 : 0);
   endtask

   task automatic insert(input int c);
      issue(1'b1, 4'(c), 1'b0, 2'd0, 1'b0, 1'b0);
   endtask

   task automatic buy(input int sel);
      issue(1'b0, 4'd0, 1'b1, 2'(sel), 1'b0, 1'b0);
   endtask

   task automatic do_cancel();
      issue(1'b0, 4'd0, 1'b0, 2'd0, 1'b1, 1'b0);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      clear_inputs();
      model_reset();
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("reset_state", int'(state), 0);
      check("reset_credit", int'(credit), 0);
      check("reset_error", int'(error), 0);
      check("reset_err_code", int'(err_code), 0);
      check("reset_busy", int'(busy), 0);
      check("reset_pulses", int'({dispense, coin_out_vld}), 0);

      // Exact price, no change.
      insert(10); insert(10); buy(3);
      // Change payout 10,5,1.
      insert(10); insert(10); insert(1); buy(0);
      // Invalid coin then a valid one, then refund.
      insert(3); insert(5); do_cancel();
      // Ceiling: 195 + 10 rejected, then long refund.
      for (int i = 0; i < 19; i++) insert(10);
      insert(5); insert(10); do_cancel();
      // Sell out product 1, then restock.
      for (int i = 0; i < 6; i++) begin
         insert(10); insert(5); buy(1);
      end
      do_cancel();
      issue(1'b0, 4'd0, 1'b0, 2'd1, 1'b0, 1'b1);
      insert(10); insert(5); buy(1);
      insert(1); buy(2);
      buy(2);

      // Reset in the middle of a change payout.
      for (int i = 0; i < 5; i++) insert(10);
      @(negedge clk);
      cancel = 1'b1;
      model_event(1'b0, 0, 1'b0, 0, 1'b1, 1'b0);
      @(negedge clk);
      clear_inputs();
      @(negedge clk);
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check("midreset_state", int'(state), 0);
      check("midreset_credit", int'(credit), 0);
      check("midreset_coin_vld", int'(coin_out_vld), 0);
      check("midreset_busy", int'(busy), 0);
      exp_q.delete();
      model_reset();
      @(negedge clk);
      rst = 1'b0;

      // Randomised mix, including simultaneous strobes to exercise priority.
      for (int n = 0; n < 300; n++) begin
         int  r;
         int  c;
         r = $urandom_range(0, 7);
         c = (r < 3) ? 10 : (r == 3) ? 5 : (r == 4) ? 1 : int'($urandom_range(0, 15));
         issue(1'($urandom_range(0, 1)), 4'(c), ($urandom_range(0, 2) == 0),
               2'($urandom_range(0, 3)), ($urandom_range(0, 9) == 0),
               ($urandom_range(0, 7) == 0));
      end

      repeat (2) @(negedge clk);
      check("pending_events", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

`default_nettype wire
